shadow_capture_mc: RTL and testbench
====================================

# shadow_capture_mc

Parametrised shadow-capture block that snapshots a wide register-state vector and serialises it out on N independent chains. It adds a single-shot/continuous capture mode, per-chain stallable dump with backpressure, and snapshot-time single-bit error injection for readout self-check. It sits beside each instrumented pipeline control block, such as the FPU add control, fed by that block's flop vector. It is the next generation of the fixed two-chain shadow capture.

## Interface
Parameters:
- `DFF_BITS`, 229: width of captured state vector.
- `CHAINS`, 2: number of serial output chains (1..8).
- `ERR_W`, 8: width of error-injection bit index.

Ports:
- `clk`  in  1: single clock; `din` is synchronous to it.
- `rst`  in  1: reset, asynchronous, active-high.
- `capture_en`  in  1: capture request, sampled each cycle.
- `capture_mode`  in  1: 0 = single-shot, 1 = continuous.
- `din`  in  DFF_BITS: state vector to snapshot.
- `err_en`  in  1: invert one snapshot bit at capture.
- `err_idx`  in  ERR_W: index of the bit to invert.
- `dump_en`  in  CHAINS: per-chain shift request, level-sensitive; low stalls the chain.
- `chains_out`  out  CHAINS: serial data.
- `chains_out_vld`  out  CHAINS: qualifies `chains_out`.
- `chains_out_done`  out  CHAINS: sticky, high when the chain is fully dumped.
- `busy`  out  1: snapshot held and not fully dumped.

## Operation
- Chain length L = ceil(DFF_BITS/CHAINS).
- Chain k carries snapshot bits [k*L +: L], LSB first. Bits beyond DFF_BITS-1 are padding and read as 0.
- Global FSM has three states:
  - EMPTY: no valid snapshot; `busy` = 0.
  - HELD: snapshot valid, no chain has started shifting.
  - DUMPING: at least one chain has emitted a bit and at least one chain is not done.
- Transitions:
  - EMPTY to HELD: `capture_en` = 1. The snapshot is loaded and all `done` bits are cleared.
  - HELD to DUMPING: any `dump_en[k]` = 1 for a chain that is not done.
  - DUMPING to EMPTY: the last remaining chain emits its final bit.
  - HELD to HELD (re-capture): allowed only when `capture_mode` = 1, `capture_en` = 1 and `dump_en` = 0 in that cycle.
- Capture rules:
  - `capture_en` is ignored in DUMPING.
  - `capture_en` is ignored in HELD when `capture_mode` = 0.
  - `dump_en` has priority over `capture_en` in the same cycle.
- Error injection: if `err_en` = 1 and `err_idx` < DFF_BITS at an accepted capture, snapshot bit `err_idx` = ~`din[err_idx]`. If `err_idx` >= DFF_BITS, injection has no effect.
- Per-chain serialiser:
  - Each serialiser has a remaining-bit counter that is loaded with L at capture.
  - In each cycle where `dump_en[k]` = 1, the state is HELD or DUMPING, and remaining > 0: the next bit is registered onto `chains_out[k]`, `chains_out_vld[k]` is set, and remaining is decremented.
  - Otherwise `chains_out_vld[k]` = 0 and `chains_out[k]` holds its value.
- `chains_out_done[k]` rises in the same cycle as the vld of chain k's last bit. It stays high until the next accepted capture or reset.
- `dump_en[k]` asserted on a done chain, or while EMPTY, produces nothing.

## Timing
- Reset values: `chains_out` = 0, `chains_out_vld` = 0, `chains_out_done` = 0, `busy` = 0, snapshot = 0, counters = 0, FSM = EMPTY.
- Capture accepted at edge t: `busy` = 1 from cycle t+1. `dump_en` may be asserted in cycle t+1, and the first bit is valid in cycle t+2.
- Output latency is one cycle from `dump_en` to `vld`. With `dump_en` held continuously, one bit per cycle; L cycles per chain.
- Chains are independent: any interleaving or stall pattern of `dump_en` yields identical per-chain bit sequences.
- Reset asserted mid-dump clears everything asynchronously. The snapshot is lost and no partial done is retained.
- `busy` falls in the cycle after the final `done` rises.

## Structure
- Package `shadow_pkg`:
  - FSM state enum {EMPTY, HELD, DUMPING}.
  - Function `chain_len(bits, chains)`.
  - Width helper for the remaining-bit counter: clog2(L+1).
- Sub-module `shadow_chain_ser`:
  - One instance per chain via generate.
  - Holds an L-bit shift register, the counter, and registered out/vld/done.
- The top level owns the snapshot load, error injection and the FSM.

## Test plan
- Reset defaults: drive `rst` = 1 -> all outputs 0. Then `dump_en` = 2'b11 with no capture -> `vld` stays 0.
- Basic dump: DFF_BITS = 229, CHAINS = 2, `din` = 229'h0123456789ABCDEF0123456789ABCDEF0123456789, capture, then `dump_en` = 2'b01 continuously.
  - First 8 bits of chain 0 are 1,0,0,1,0,0,0,1.
  - `done[0]` rises on the 115th vld.
  - Chain 1's 115th bit reads 0 (padding).
- Error injection: capture with `err_en` = 1, `err_idx` = 3 -> chain 0 bit 3 reads 0. Repeat with `err_idx` = 240 -> no change.
- Mode and priority:
  - `capture_mode` = 0: a second capture in HELD is ignored and the old data dumps.
  - `capture_mode` = 1: a second capture replaces the snapshot.
  - `capture_en` and `dump_en` in the same cycle -> old data dumps.
- Stall and interleave: toggle `dump_en[0]` randomly and hold `dump_en[1]` = 1 -> both sequences are correct. `busy` falls one cycle after the last `done`, and a new capture is then accepted.
- Reset mid-dump: assert `rst` after 50 bits -> outputs 0 immediately and FSM = EMPTY. `dump_en` after release yields no `vld`.

Source files
------------

// File: rtl/shadow_capture_mc_pkg.sv
// rtl/shadow_capture_mc_pkg.sv - shared types and sizing helpers for shadow_capture_mc
// Contents: FSM state enum, chain length and remaining-counter width helpers.
package shadow_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HELD    = 2'd1,
        DUMPING = 2'd2
    } state_t;

    // Bits per chain; the last chain is padded with zeros up to this length.
    function automatic int chain_len(int bits, int chains);
        return (bits + chains - 1) / chains;
    endfunction

    // Counter must hold the value L itself, hence L+1 states.
    function automatic int cnt_w(int l);
        return $clog2(l + 1);
    endfunction

endpackage

// File: rtl/shadow_capture_mc_if.sv
// rtl/shadow_capture_mc_if.sv - capture/dump bus between a controller and shadow_capture_mc
// Signals: capture_en, capture_mode, din, err_en, err_idx, dump_en (to block);
//          chains_out, chains_out_vld, chains_out_done, busy (from block).
interface shadow_capture_mc_if
    import shadow_pkg::*;
#(
    parameter int DFF_BITS = 229,
    parameter int CHAINS   = 2,
    parameter int ERR_W    = 8
) ();
    logic                capture_en;
    logic                capture_mode;
    logic [DFF_BITS-1:0] din;
    logic                err_en;
    logic [ERR_W-1:0]    err_idx;
    logic [CHAINS-1:0]   dump_en;
    logic [CHAINS-1:0]   chains_out;
    logic [CHAINS-1:0]   chains_out_vld;
    logic [CHAINS-1:0]   chains_out_done;
    logic                busy;

    modport master (
        output capture_en, capture_mode, din, err_en, err_idx, dump_en,
        input  chains_out, chains_out_vld, chains_out_done, busy
    );

    modport slave (
        input  capture_en, capture_mode, din, err_en, err_idx, dump_en,
        output chains_out, chains_out_vld, chains_out_done, busy
    );
endinterface

// File: rtl/shadow_capture_mc_chain_ser.sv
// rtl/shadow_capture_mc_chain_ser.sv - one stallable LSB-first serialiser chain
// Ports: clk, rst; load/data (snapshot slice); shift_req (dump_en bit), active (snapshot valid);
//        shifting (bit leaves this cycle); sout/vld/done registered outputs.
module shadow_chain_ser #(
    parameter int L  = 115,
    parameter int CW = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [L-1:0] data,
    input  logic         shift_req,
    input  logic         active,
    output logic         shifting,
    output logic         sout,
    output logic         vld,
    output logic         done
);
    logic [L-1:0]  sr;
    logic [CW-1:0] rem;

    assign shifting = shift_req && active && (rem != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            rem  <= '0;
            sout <= 1'b0;
            vld  <= 1'b0;
            done <= 1'b0;
        end else begin
            vld <= shifting;
            if (load) begin
                sr   <= data;
                rem  <= CW'(L);
                done <= 1'b0;
            end else if (shifting) begin
                sout <= sr[0];
                sr   <= sr >> 1;
                rem  <= rem - CW'(1);
                // done rises together with the vld of the final bit
                if (rem == CW'(1)) done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/shadow_capture_mc.sv
// rtl/shadow_capture_mc.sv - snapshot a state vector and dump it on independent serial chains
// Ports: clk, rst (async, active-high); bus (slave modport of shadow_capture_mc_if).
module shadow_capture_mc
    import shadow_pkg::*;
#(
    parameter int DFF_BITS = 229,
    parameter int CHAINS   = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shadow_capture_mc_if.slave   bus
);
    localparam int L  = chain_len(DFF_BITS, CHAINS);
    localparam int CW = cnt_w(L);

    state_t              state, state_nxt;
    logic [CHAINS*L-1:0] snap_in;
    logic [CHAINS-1:0]   shifting, out_b, vld_b, done_b;
    logic                cap_accept;
    logic                active;
    logic [31:0]         idx32;

    assign active = (state != EMPTY);

    // Re-capture in HELD only in continuous mode and only when no chain is asking to shift.
    assign cap_accept = bus.capture_en &&
                        ((state == EMPTY) ||
                         ((state == HELD) && bus.capture_mode && (bus.dump_en == '0)));

    // Padded snapshot image with optional single-bit inversion; out-of-range index matches nothing.
    always_comb begin
        snap_in = '0;
        idx32   = 32'(bus.err_idx);
        for (int i = 0; i < DFF_BITS; i++) begin
            snap_in[i] = bus.din[i] ^ (bus.err_en && (idx32 == 32'($unsigned(i))));
        end
    end

    for (genvar k = 0; k < CHAINS; k++) begin : g_chain
        shadow_chain_ser #(.L(L), .CW(CW)) u_ser (
            .clk       (clk),
            .rst       (rst),
            .load      (cap_accept),
            .data      (snap_in[k*L +: L]),
            .shift_req (bus.dump_en[k]),
            .active    (active),
            .shifting  (shifting[k]),
            .sout      (out_b[k]),
            .vld       (vld_b[k]),
            .done      (done_b[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Leaving DUMPING waits for the registered done bits, so busy drops the cycle after the last done.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (cap_accept) state_nxt = HELD;
            HELD:    if (|shifting)  state_nxt = DUMPING;
            DUMPING: if (&done_b)    state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign bus.chains_out      = out_b;
    assign bus.chains_out_vld  = vld_b;
    assign bus.chains_out_done = done_b;
    assign bus.busy            = active;
endmodule

// File: tb/tb_shadow_capture_mc.sv
// tb/tb_shadow_capture_mc.sv - self-checking bench for shadow_capture_mc
module tb_shadow_capture_mc;
    import shadow_pkg::*;

    localparam int DFF = 229;
    localparam int CH  = 2;
    localparam int EW  = 8;
    localparam int L   = (DFF + CH - 1) / CH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shadow_capture_mc_if #(.DFF_BITS(DFF), .CHAINS(CH), .ERR_W(EW)) bus ();
    shadow_capture_mc #(.DFF_BITS(DFF), .CHAINS(CH), .ERR_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-chain queues of bits still to be emitted.
    bit          mq  [CH][$];
    bit          obs [CH][$];
    logic [CH-1:0] exp_vld, exp_out, m_done;
    bit          m_valid, m_started;
    int          vld_cnt0, done0_at;

    logic [DFF-1:0] kvec, va, vb;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) mq[k].delete();
        exp_vld = '0; exp_out = '0; m_done = '0;
        m_valid = 0; m_started = 0;
    endtask

    task automatic model_load();
        bit b;
        int idx;
        for (int k = 0; k < CH; k++) begin
            mq[k].delete();
            for (int i = 0; i < L; i++) begin
                idx = k * L + i;
                if (idx < DFF) begin
                    b = bus.din[idx];
                    if (bus.err_en && int'(bus.err_idx) == idx) b = ~b;
                end else begin
                    b = 1'b0;
                end
                mq[k].push_back(b);
            end
        end
        m_done = '0; m_valid = 1; m_started = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] sh;
        bit all_done_pre, accept;
        if (rst) begin
            model_reset();
            return;
        end
        all_done_pre = &m_done;
        for (int k = 0; k < CH; k++) sh[k] = bus.dump_en[k] && m_valid && (mq[k].size() > 0);
        accept = bus.capture_en &&
                 (!m_valid || (!m_started && bus.capture_mode && bus.dump_en == '0));
        exp_vld = sh;
        for (int k = 0; k < CH; k++) begin
            if (sh[k]) begin
                exp_out[k] = mq[k].pop_front();
                if (mq[k].size() == 0) m_done[k] = 1'b1;
            end
        end
        if (|sh) m_started = 1;
        if (accept) model_load();
        else if (m_valid && all_done_pre) m_valid = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("vld",  32'(bus.chains_out_vld),  32'(exp_vld));
        chk("out",  32'(bus.chains_out),      32'(exp_out));
        chk("done", 32'(bus.chains_out_done), 32'(m_done));
        chk("busy", 32'(bus.busy),            32'(m_valid));
        for (int k = 0; k < CH; k++) begin
            if (bus.chains_out_vld[k]) begin
                obs[k].push_back(bus.chains_out[k]);
                if (k == 0) vld_cnt0++;
            end
        end
        if (bus.chains_out_done[0] && done0_at < 0) done0_at = vld_cnt0;
    endtask

    task automatic clear_obs();
        for (int k = 0; k < CH; k++) obs[k].delete();
        vld_cnt0 = 0; done0_at = -1;
    endtask

    task automatic capture(input logic [DFF-1:0] d, input bit mode, input bit ee, input int ei);
        bus.din = d; bus.capture_mode = mode; bus.err_en = ee; bus.err_idx = EW'(ei);
        bus.capture_en = 1'b1;
        tick();
        bus.capture_en = 1'b0; bus.err_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.dump_en = '1;
        while (m_valid && n < 400) begin
            tick();
            n++;
        end
        bus.dump_en = '0;
        tick();
        chk("drain_idle", 32'(bus.busy), 32'(0));
    endtask

    task automatic rand_vec(output logic [DFF-1:0] v);
        for (int i = 0; i < DFF; i++) v[i] = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] first32();
        logic [31:0] r = '0;
        for (int i = 0; i < 32 && i < obs[0].size(); i++) r[i] = obs[0][i];
        return r;
    endfunction

    initial begin
        logic [7:0] b8;
        int n;
        rst = 1'b1;
        bus.capture_en = 0; bus.capture_mode = 0; bus.din = '0;
        bus.err_en = 0; bus.err_idx = '0; bus.dump_en = '0;
        model_reset();
        clear_obs();
        kvec = 229'h0123456789ABCDEF0123456789ABCDEF0123456789;

        // reset defaults, then dump request with nothing captured
        repeat (2) tick();
        rst = 1'b0;
        bus.dump_en = 2'b11;
        repeat (3) tick();
        bus.dump_en = '0;
        tick();

        // basic dump, chain 0 then chain 1
        clear_obs();
        capture(kvec, 0, 0, 0);
        bus.dump_en = 2'b01;
        repeat (L) tick();
        for (int i = 0; i < 8; i++) b8[i] = obs[0][i];
        chk("first8", 32'(b8), 32'h89);
        chk("done0_at", 32'(done0_at), 32'd115);
        bus.dump_en = 2'b10;
        repeat (L) tick();
        chk("ch1_len", 32'(obs[1].size()), 32'(L));
        chk("pad_bit", 32'(obs[1][L-1]), 32'd0);
        bus.dump_en = '0;
        repeat (2) tick();
        chk("basic_idle", 32'(bus.busy), 32'd0);

        // error injection in range and out of range
        clear_obs();
        capture(kvec, 0, 1, 3);
        drain();
        chk("inj3", 32'(obs[0][3]), 32'd0);
        clear_obs();
        capture(kvec, 0, 1, 240);
        drain();
        chk("inj240", 32'(obs[0][3]), 32'd1);

        // single-shot ignores re-capture
        rand_vec(va); rand_vec(vb); vb[0] = ~va[0];
        clear_obs();
        capture(va, 0, 0, 0);
        capture(vb, 0, 0, 0);
        drain();
        chk("mode0_keep", first32(), va[31:0]);

        // continuous replaces
        clear_obs();
        capture(va, 1, 0, 0);
        capture(vb, 1, 0, 0);
        drain();
        chk("mode1_repl", first32(), vb[31:0]);

        // dump_en wins over capture_en in the same cycle
        clear_obs();
        capture(va, 1, 0, 0);
        bus.din = vb; bus.capture_en = 1'b1; bus.dump_en = 2'b01;
        tick();
        bus.capture_en = 1'b0;
        drain();
        chk("prio_old", first32(), va[31:0]);

        // random stall on chain 0, chain 1 continuous
        rand_vec(va);
        clear_obs();
        capture(va, 0, 0, 0);
        n = 0;
        while (m_valid && n < 1000) begin
            bus.dump_en = {1'b1, 1'($urandom_range(0, 1))};
            tick();
            n++;
        end
        bus.dump_en = '0;
        chk("stall_len0", 32'(obs[0].size()), 32'(L));
        chk("stall_len1", 32'(obs[1].size()), 32'(L));
        chk("stall_idle", 32'(bus.busy), 32'd0);
        rand_vec(vb);
        capture(vb, 0, 0, 0);
        chk("recapture", 32'(bus.busy), 32'd1);
        drain();

        // asynchronous reset in the middle of a dump
        rand_vec(va);
        capture(va, 0, 0, 0);
        bus.dump_en = 2'b11;
        repeat (50) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_vld",  32'(bus.chains_out_vld),  32'd0);
        chk("rst_out",  32'(bus.chains_out),      32'd0);
        chk("rst_done", 32'(bus.chains_out_done), 32'd0);
        chk("rst_busy", 32'(bus.busy),            32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        bus.dump_en = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
